// File: rtl/imem_arbiter_if.sv
// -----------------------------------------------------------------------------
// imem_arbiter_if
// Bundles the fetch requester, the debug/loader requester and the IMEM read
// port that meet at the instruction-memory arbiter.
//   slave  : arbiter side (takes requests and IMEM data, drives grants,
//            responses, lock status and the IMEM read controls)
//   master : requester / memory side (the opposite directions)
// Parameter ADDR_DEPTH: IMEM word-address width.
// -----------------------------------------------------------------------------
interface imem_arbiter_if #(
  parameter int ADDR_DEPTH = 14
);
  // fetch requester
  logic                  fetch_req;
  logic [ADDR_DEPTH-1:0] fetch_addr;
  logic                  fetch_gnt;
  logic                  fetch_valid;
  logic [31:0]           fetch_data;
  // debug/loader requester
  logic                  dbg_req;
  logic [ADDR_DEPTH-1:0] dbg_addr;
  logic                  dbg_lock;
  logic                  dbg_gnt;
  logic                  dbg_valid;
  logic [31:0]           dbg_data;
  logic                  locked;
  // IMEM read port
  logic                  imem_rden;
  logic [ADDR_DEPTH-1:0] imem_addr;
  logic [31:0]           imem_data;

  modport slave (
    input  fetch_req, fetch_addr, dbg_req, dbg_addr, dbg_lock, imem_data,
    output fetch_gnt, fetch_valid, fetch_data,
    output dbg_gnt, dbg_valid, dbg_data, locked,
    output imem_rden, imem_addr
  );

  modport master (
    output fetch_req, fetch_addr, dbg_req, dbg_addr, dbg_lock, imem_data,
    input  fetch_gnt, fetch_valid, fetch_data,
    input  dbg_gnt, dbg_valid, dbg_data, locked,
    input  imem_rden, imem_addr
  );
endinterface

// File: rtl/imem_arbiter.sv
// -----------------------------------------------------------------------------
// imem_arbiter
// Shares the single synchronous read port of the instruction memory between
// the core fetch stage and the debug/loader port. Grants are combinational,
// the read data returns one cycle after the grant and is steered to the
// requester recorded in the owner tag; each requester's data output holds its
// last word until its next response. A debug lock (LOCK state) gives the
// debug port exclusive ownership.
//
// Ports:
//   i_clk   : system clock, rising edge
//   i_rst   : asynchronous active-high reset
//   io_bus  : imem_arbiter_if.slave (requests, grants, responses, lock, IMEM)
//
// Build option:
//   IMEM_ARB_RR_EN defined   -> round-robin between contending requesters
//   IMEM_ARB_RR_EN undefined -> fixed priority, fetch always wins
// -----------------------------------------------------------------------------
module imem_arbiter #(
  parameter int ADDR_DEPTH = 14
) (
  input  logic           i_clk,
  input  logic           i_rst,
  imem_arbiter_if.slave  io_bus
);

  typedef enum logic [0:0] {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  // owner tag: bit 0 = fetch response due, bit 1 = debug response due
  logic [1:0]            r_owner;
  logic [31:0]           r_fetch_data;
  logic [31:0]           r_dbg_data;
  logic                  w_fetch_gnt;
  logic                  w_dbg_gnt;
  logic [ADDR_DEPTH-1:0] w_imem_addr;
  logic [31:0]           w_fetch_data;
  logic [31:0]           w_dbg_data;

`ifdef IMEM_ARB_RR_EN
  // 0: fetch wins the next contended cycle, 1: debug wins it
  logic                  r_rr_ptr;
  logic                  w_contend;
`endif

  // FSM state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_ARB;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic: the lock request is sampled every edge
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ARB: begin
        if (io_bus.dbg_lock) begin
          w_state_nxt = ST_LOCK;
        end else begin
          w_state_nxt = ST_ARB;
        end
      end
      ST_LOCK: begin
        if (!io_bus.dbg_lock) begin
          w_state_nxt = ST_ARB;
        end else begin
          w_state_nxt = ST_LOCK;
        end
      end
      default: begin
        w_state_nxt = ST_ARB;
      end
    endcase
  end

  // FSM output logic: grant decision (never more than one grant per cycle)
  always_comb begin
    w_fetch_gnt = 1'b0;
    w_dbg_gnt   = 1'b0;
`ifdef IMEM_ARB_RR_EN
    w_contend   = io_bus.fetch_req & io_bus.dbg_req;
`endif
    if (i_rst) begin
      // nothing may be granted while reset is held
      w_fetch_gnt = 1'b0;
      w_dbg_gnt   = 1'b0;
    end else begin
      case (r_state)
        ST_ARB: begin
`ifdef IMEM_ARB_RR_EN
          if (w_contend) begin
            w_fetch_gnt = ~r_rr_ptr;
            w_dbg_gnt   = r_rr_ptr;
          end else begin
            w_fetch_gnt = io_bus.fetch_req;
            w_dbg_gnt   = io_bus.dbg_req;
          end
`else
          w_fetch_gnt = io_bus.fetch_req;
          w_dbg_gnt   = io_bus.dbg_req & ~io_bus.fetch_req;
`endif
        end
        ST_LOCK: begin
          w_fetch_gnt = 1'b0;
          w_dbg_gnt   = io_bus.dbg_req;
        end
        default: begin
          w_fetch_gnt = 1'b0;
          w_dbg_gnt   = 1'b0;
        end
      endcase
    end
  end

`ifdef IMEM_ARB_RR_EN
  // Round-robin pointer: only contended ARB cycles move it, toward the loser
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rr_ptr <= 1'b0;
    end else if ((r_state == ST_ARB) && w_contend) begin
      r_rr_ptr <= w_fetch_gnt;
    end else begin
      r_rr_ptr <= r_rr_ptr;
    end
  end
`endif

  // IMEM address mux: granted requester's address, zero when idle
  always_comb begin
    w_imem_addr = {ADDR_DEPTH{1'b0}};
    if (w_fetch_gnt) begin
      w_imem_addr = io_bus.fetch_addr;
    end else if (w_dbg_gnt) begin
      w_imem_addr = io_bus.dbg_addr;
    end else begin
      w_imem_addr = {ADDR_DEPTH{1'b0}};
    end
  end

  // Owner tag: records this cycle's winner so next cycle's IMEM word is routed
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_owner <= 2'b00;
    end else begin
      r_owner <= {w_dbg_gnt, w_fetch_gnt};
    end
  end

  // Hold registers: capture the word during its response cycle only
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_fetch_data <= 32'h0000_0000;
      r_dbg_data   <= 32'h0000_0000;
    end else begin
      if (r_owner[0]) begin
        r_fetch_data <= io_bus.imem_data;
      end else begin
        r_fetch_data <= r_fetch_data;
      end
      if (r_owner[1]) begin
        r_dbg_data <= io_bus.imem_data;
      end else begin
        r_dbg_data <= r_dbg_data;
      end
    end
  end

  // Data outputs: the IMEM's registered output is shown directly in the
  // response cycle (it only becomes available then); otherwise the held word
  always_comb begin
    w_fetch_data = r_fetch_data;
    w_dbg_data   = r_dbg_data;
    if (r_owner[0]) begin
      w_fetch_data = io_bus.imem_data;
    end else begin
      w_fetch_data = r_fetch_data;
    end
    if (r_owner[1]) begin
      w_dbg_data = io_bus.imem_data;
    end else begin
      w_dbg_data = r_dbg_data;
    end
  end

  assign io_bus.fetch_gnt   = w_fetch_gnt;
  assign io_bus.dbg_gnt     = w_dbg_gnt;
  assign io_bus.imem_rden   = w_fetch_gnt | w_dbg_gnt;
  assign io_bus.imem_addr   = w_imem_addr;
  assign io_bus.fetch_valid = r_owner[0];
  assign io_bus.dbg_valid   = r_owner[1];
  assign io_bus.fetch_data  = w_fetch_data;
  assign io_bus.dbg_data    = w_dbg_data;
  assign io_bus.locked      = (r_state == ST_LOCK);

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

- Shares the single synchronous read port of the instruction memory between two requesters:
  - the core's instruction fetch stage;
  - the debug/loader port, used for program readback and verification.
- Sits directly in front of the IMEM:
  - drives its read enable and address;
  - routes the one-cycle-latency read data back to whichever requester was granted;
  - holds each requester's last word until that requester's next response.
- Also provides a debug lock that gives the debug port exclusive ownership during bursts.

## Interface

Parameters:
- ADDR_DEPTH, default 14: IMEM word-address width (2^ADDR_DEPTH words of 32 bits).

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-high reset.
- FETCH_REQ  in  1  fetch read request; held with FETCH_ADDR stable until FETCH_GNT.
- FETCH_ADDR  in  ADDR_DEPTH  fetch word address.
- FETCH_GNT  out  1  combinational; fetch request accepted this cycle.
- FETCH_VALID  out  1  registered; FETCH_DATA holds a new word this cycle.
- FETCH_DATA  out  32  fetch read data; holds last word.
- DBG_REQ  in  1  debug read request; same handshake as fetch.
- DBG_ADDR  in  ADDR_DEPTH  debug word address.
- DBG_LOCK  in  1  request exclusive debug ownership.
- DBG_GNT  out  1  combinational; debug request accepted this cycle.
- DBG_VALID  out  1  registered; DBG_DATA holds a new word this cycle.
- DBG_DATA  out  32  debug read data; holds last word.
- LOCKED  out  1  registered; arbiter is in LOCK state.
- IMEM_RDEN  out  1  to IMEM read enable.
- IMEM_ADDR  out  ADDR_DEPTH  to IMEM address.
- IMEM_DATA  in  32  from IMEM registered output.

## Operation

State machine:
- States: ARB (reset state) and LOCK.
- ARB -> LOCK on the edge where DBG_LOCK=1.
- LOCK -> ARB on the edge where DBG_LOCK=0.
- LOCKED=1 exactly when in LOCK.

ARB behaviour:
- At most one grant per cycle.
- Only FETCH_REQ: grant fetch.
- Only DBG_REQ: grant debug.
- Both: resolved per Configuration.

LOCK behaviour:
- FETCH_GNT is forced to 0.
- DBG_GNT = DBG_REQ.

Grant cycle N:
- IMEM_RDEN=1.
- IMEM_ADDR = the granted requester's address.
- A registered owner tag records the winner.

No grant:
- IMEM_RDEN=0.
- IMEM_ADDR = 0.

Response cycle N+1:
- IMEM_DATA is captured into the owner's DATA register.
- The owner's VALID is asserted for exactly one cycle.
- The other requester's VALID=0 and its DATA is unchanged.

Throughput and hold rules:
- Grants may occur back-to-back, giving one word per cycle sustained.
- A requester that is not granted keeps REQ and ADDR stable; no request is ever dropped.
- FETCH_DATA and DBG_DATA are never overwritten by the other requester's response.

Reset (RST=1, any cycle):
- State=ARB, LOCKED=0.
- FETCH_VALID=0, DBG_VALID=0.
- FETCH_DATA=0, DBG_DATA=0.
- Owner tag cleared; round-robin pointer = fetch-preferred.
- A read granted in the cycle before reset produces no VALID.
- GNT and IMEM_RDEN are 0 while RST=1.

## Timing

- REQ to GNT: 0 cycles (combinational), subject to arbitration.
- GNT to VALID/DATA: exactly 1 cycle.
- Lock entry: DBG_LOCK rising at edge k.
  - Arbitration in the cycle before edge k still follows ARB rules.
  - Fetch is blocked from the cycle after edge k.
- Lock exit: fetch becomes grantable in the cycle after the edge where DBG_LOCK=0 is sampled.
- A response already in flight when the state changes is always delivered to its original owner.

## Configuration

Macro IMEM_ARB_RR_EN selects how simultaneous ARB requests are resolved.

Defined:
- Round-robin arbitration.
- A one-bit pointer records the last requester granted under contention.
- The other requester wins the next contended cycle.
- Uncontended grants do not move the pointer.
- Reset pointer favours fetch.

Undefined:
- Fixed priority: fetch always wins.
- Debug is served only when fetch is idle or in LOCK.
- No pointer register exists.

## Test plan

- Single fetch: FETCH_REQ=1, ADDR=0x0010 for one cycle, IMEM word 0xDEADBEEF.
  - FETCH_GNT=1 and IMEM_RDEN=1 with IMEM_ADDR=0x0010 that cycle.
  - Next cycle FETCH_VALID=1, FETCH_DATA=0xDEADBEEF; DBG_VALID=0.
- Back-to-back fetch at addresses 0,1,2,3 with continuous request.
  - Four consecutive grants.
  - FETCH_VALID high for 4 cycles, one cycle late, in address order.
  - FETCH_DATA holds the word at address 3 afterwards.
- Contention: both requesters request continuously for 4 cycles.
  - RR_EN defined: grants are F,D,F,D.
  - RR_EN undefined: grants are F,F,F,F with debug stalled.
  - In both cases DBG_ADDR is honoured when debug is finally granted.
- Lock: assert DBG_LOCK while FETCH_REQ=1, then issue two debug reads.
  - LOCKED=1 the cycle after DBG_LOCK is sampled.
  - FETCH_GNT=0 throughout LOCK; both debug reads are granted and valid.
  - After DBG_LOCK is deasserted, fetch is granted on the next cycle.
- Reset mid-read: assert RST in the cycle after a fetch grant.
  - FETCH_VALID stays 0 and FETCH_DATA=0.
  - LOCKED=0 and no grants while RST=1.
  - Normal operation resumes after release.
- Data isolation: debug read returns 0x12345678, then fetch read returns 0xCAFEF00D.
  - DBG_DATA remains 0x12345678 throughout.
